alu_rr_scheduler: RTL and testbench

- Shares one 32-bit combinational ALU among N_REQ requesters using round-robin arbitration with valid/ready handshakes.
- Decodes a 2-bit opcode into the ALU control pins: Operation, Binvert and CarryIn.
- Registers the operands, captures Result/CarryOut one cycle later and returns a tagged response.
- Sits between the execution-unit clients and the shared ALU instance.

---
 rtl/alu_sched_pkg.sv | 46 ++++
 rtl/alu_rr_scheduler_if.sv | 43 ++++
 rtl/rr_arbiter.sv | 35 +++
 rtl/alu_rr_scheduler.sv | 109 ++++++++++
 tb/tb_alu_rr_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and helpers for the round-robin ALU scheduler.
//   op_e        : requester opcode (AND, OR, ADD, SUB)
//   ALU_SEL_*   : ALU Operation select codes (code 2'b11 is never driven)
//   state_e     : scheduler FSM states
//   alu_ctrl_t  : decoded ALU control pins
//   decode_op() : opcode -> {Operation, Binvert, CarryIn}
package alu_sched_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    localparam logic [1:0] ALU_SEL_AND = 2'b00;
    localparam logic [1:0] ALU_SEL_OR  = 2'b01;
    localparam logic [1:0] ALU_SEL_SUM = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    typedef struct packed {
        logic [1:0] operation;
        logic       binvert;
        logic       carryin;
    } alu_ctrl_t;

    // SUB is realised as a + ~b + 1 on the adder path.
    function automatic alu_ctrl_t decode_op(input op_e op);
        alu_ctrl_t ctrl;
        ctrl = '{operation: ALU_SEL_AND, binvert: 1'b0, carryin: 1'b0};
        case (op)
            OP_AND:  ctrl = '{operation: ALU_SEL_AND, binvert: 1'b0, carryin: 1'b0};
            OP_OR:   ctrl = '{operation: ALU_SEL_OR,  binvert: 1'b0, carryin: 1'b0};
            OP_ADD:  ctrl = '{operation: ALU_SEL_SUM, binvert: 1'b0, carryin: 1'b0};
            OP_SUB:  ctrl = '{operation: ALU_SEL_SUM, binvert: 1'b1, carryin: 1'b1};
            default: ctrl = '{operation: ALU_SEL_AND, binvert: 1'b0, carryin: 1'b0};
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Bundle of the requester, response and shared-ALU signals of the scheduler.
//   req_*   : N_REQ packed requests (valid/ready per requester, op/a/b slices)
//   resp_*  : single tagged response channel (valid/ready)
//   alu_*   : control/operands to and Result/CarryOut from the shared ALU
// Modports: slave = scheduler side, master = clients + ALU side.
interface alu_rr_scheduler_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) ();

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [2*N_REQ-1:0]  req_op;
    logic [32*N_REQ-1:0] req_a;
    logic [32*N_REQ-1:0] req_b;

    logic                resp_valid;
    logic                resp_ready;
    logic [ID_W-1:0]     resp_id;
    logic [31:0]         resp_result;
    logic                resp_carry;

    logic [31:0]         alu_a;
    logic [31:0]         alu_b;
    logic [1:0]          alu_operation;
    logic                alu_binvert;
    logic                alu_carryin;
    logic [31:0]         alu_result;
    logic                alu_carryout;

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready, alu_result, alu_carryout,
        output req_ready, resp_valid, resp_id, resp_result, resp_carry,
        output alu_a, alu_b, alu_operation, alu_binvert, alu_carryin
    );

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready, alu_result, alu_carryout,
        input  req_ready, resp_valid, resp_id, resp_result, resp_carry,
        input  alu_a, alu_b, alu_operation, alu_binvert, alu_carryin
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i        : request vector
//   last_grant_i : index granted most recently; search starts one above it
//   grant_o      : one-hot grant (all zero when no request)
//   grant_idx_o  : binary index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_grant_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  grant_idx_o
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Visit last+1, last+2, ... wrapping modulo N_REQ; the first hit wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = ID_W'((32'(last_grant_i) + i) % N_REQ);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational 32-bit ALU among N_REQ requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester/response/ALU bundle (slave modport)
// Flow: IDLE grants one requester round-robin and registers its operands and
// decoded ALU controls; EXEC lets the ALU settle for one cycle and captures
// Result/CarryOut; RESP holds the tagged response until it is consumed.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_rr_scheduler_if.slave bus
);

    state_e          state_q;
    logic [ID_W-1:0] last_grant_q;
    logic            resp_valid_q;
    logic [ID_W-1:0] resp_id_q;
    logic [31:0]     resp_result_q;
    logic            resp_carry_q;
    logic [31:0]     alu_a_q;
    logic [31:0]     alu_b_q;
    logic [1:0]      alu_op_q;
    logic            alu_binvert_q;
    logic            alu_carryin_q;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    op_e              sel_op;
    alu_ctrl_t        sel_ctrl;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i        (bus.req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    assign sel_op   = op_e'(bus.req_op[2*grant_idx +: 2]);
    assign sel_ctrl = decode_op(sel_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= ID_W'(N_REQ - 1);
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_carry_q  <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= ALU_SEL_AND;
            alu_binvert_q <= 1'b0;
            alu_carryin_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.req_valid) begin
                        alu_a_q       <= bus.req_a[32*grant_idx +: 32];
                        alu_b_q       <= bus.req_b[32*grant_idx +: 32];
                        alu_op_q      <= sel_ctrl.operation;
                        alu_binvert_q <= sel_ctrl.binvert;
                        alu_carryin_q <= sel_ctrl.carryin;
                        last_grant_q  <= grant_idx;
                        resp_id_q     <= grant_idx;
                        state_q       <= EXEC;
                    end
                end
                EXEC: begin
                    resp_result_q <= bus.alu_result;
                    // Logic ops report no carry even though the adder still produces one.
                    resp_carry_q  <= (alu_op_q == ALU_SEL_SUM) && bus.alu_carryout;
                    resp_valid_q  <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    // Gated by rst_n so no grant is offered while reset is held.
    assign bus.req_ready     = (rst_n && state_q == IDLE) ? grant : '0;

    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_id       = resp_id_q;
    assign bus.resp_result   = resp_result_q;
    assign bus.resp_carry    = resp_carry_q;
    assign bus.alu_a         = alu_a_q;
    assign bus.alu_b         = alu_b_q;
    assign bus.alu_operation = alu_op_q;
    assign bus.alu_binvert   = alu_binvert_q;
    assign bus.alu_carryin   = alu_carryin_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: directed vector table, round-robin
// fairness run, randomized run against a reference model, stall and reset cases.
module tb_alu_rr_scheduler;
    import alu_sched_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_rr_scheduler_if #(.N_REQ(N), .ID_W(IW)) bus ();

    alu_rr_scheduler #(
        .N_REQ (N),
        .ID_W  (IW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Shared ALU: AND / OR / full adder with Binvert and CarryIn.
    logic [32:0] alu_sum;
    assign alu_sum = {1'b0, bus.alu_a} + {1'b0, (bus.alu_binvert ? ~bus.alu_b : bus.alu_b)}
                   + 33'(bus.alu_carryin);
    always_comb begin
        bus.alu_carryout = alu_sum[32];
        case (bus.alu_operation)
            2'b00:   bus.alu_result = bus.alu_a & bus.alu_b;
            2'b01:   bus.alu_result = bus.alu_a | bus.alu_b;
            2'b10:   bus.alu_result = alu_sum[31:0];
            default: bus.alu_result = 32'hDEAD_BEEF;
        endcase
    end

    int errors = 0;
    int checks = 0;
    int m_last = N - 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: {carry, result}. SUB carry means a >= b (no borrow).
    function automatic logic [32:0] ref_alu(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            2'b00:   return {1'b0, a & b};
            2'b01:   return {1'b0, a | b};
            2'b10:   return {1'b0, a} + {1'b0, b};
            default: return {(a >= b), a - b};
        endcase
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic check_reset(input string tag);
        check({tag, " req_ready"},     64'(bus.req_ready), 0);
        check({tag, " resp_valid"},    64'(bus.resp_valid), 0);
        check({tag, " resp_id"},       64'(bus.resp_id), 0);
        check({tag, " resp_result"},   64'(bus.resp_result), 0);
        check({tag, " resp_carry"},    64'(bus.resp_carry), 0);
        check({tag, " alu_a"},         64'(bus.alu_a), 0);
        check({tag, " alu_b"},         64'(bus.alu_b), 0);
        check({tag, " alu_operation"}, 64'(bus.alu_operation), 0);
        check({tag, " alu_binvert"},   64'(bus.alu_binvert), 0);
        check({tag, " alu_carryin"},   64'(bus.alu_carryin), 0);
    endtask

    typedef struct {
        int          rq;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        binv;
        logic        cin;
        logic [1:0]  sel;
    } vec_t;

    // Entered and left one tick after a clock edge with the DUT idle.
    task automatic single_txn(input vec_t v);
        bus.req_valid           = '0;
        bus.req_valid[v.rq]     = 1'b1;
        bus.req_op[2*v.rq +: 2] = v.op;
        bus.req_a[32*v.rq +: 32] = v.a;
        bus.req_b[32*v.rq +: 32] = v.b;
        bus.resp_ready          = 1'b0;
        #1;
        check("vec grant", 64'(bus.req_ready), 64'(1) << v.rq);
        m_last = v.rq;
        @(posedge clk); #1;
        bus.req_valid = '0;
        check("vec alu_a", 64'(bus.alu_a), 64'(v.a));
        check("vec alu_b", 64'(bus.alu_b), 64'(v.b));
        check("vec alu_operation", 64'(bus.alu_operation), 64'(v.sel));
        check("vec alu_binvert", 64'(bus.alu_binvert), 64'(v.binv));
        check("vec alu_carryin", 64'(bus.alu_carryin), 64'(v.cin));
        check("vec resp_valid early", 64'(bus.resp_valid), 0);
        @(posedge clk); #1;
        check("vec resp_valid", 64'(bus.resp_valid), 1);
        check("vec resp_id", 64'(bus.resp_id), 64'(v.rq));
        check("vec resp_result", 64'(bus.resp_result), 64'(v.res));
        check("vec resp_carry", 64'(bus.resp_carry), 64'(v.c));
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check("vec resp_valid drop", 64'(bus.resp_valid), 0);
        bus.resp_ready = 1'b0;
    endtask

    // Cycle-level run against the model; fair=1 holds every requester valid.
    task automatic run_random(input int ncyc, input bit fair);
        int          c        = 0;
        int          acc_n    = 0;
        int          prev_acc = 0;
        int          start    = m_last;
        bit          have     = 1'b0;
        int          acc_c    = 0;
        int          t_id     = 0;
        logic [32:0] t_exp    = '0;
        bit          exp_rv;
        int          g;
        logic [1:0]  ops [N];
        logic [31:0] as_ [N];
        logic [31:0] bs_ [N];
        while (c < ncyc || (have && c < ncyc + 12)) begin
            exp_rv = have && (c - acc_c >= 2);
            check("rnd resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
            if (exp_rv) begin
                check("rnd resp_id", 64'(bus.resp_id), 64'(t_id));
                check("rnd resp_result", 64'(bus.resp_result), 64'(t_exp[31:0]));
                check("rnd resp_carry", 64'(bus.resp_carry), 64'(t_exp[32]));
            end
            check("alu_operation legal", 64'(bus.alu_operation == 2'b11), 0);
            for (int i = 0; i < N; i++) begin
                ops[i] = 2'($urandom);
                as_[i] = pick_operand();
                bs_[i] = pick_operand();
                bus.req_op[2*i +: 2]  = ops[i];
                bus.req_a[32*i +: 32] = as_[i];
                bus.req_b[32*i +: 32] = bs_[i];
            end
            if (c >= ncyc) begin
                bus.req_valid  = '0;
                bus.resp_ready = 1'b1;
            end else if (fair) begin
                bus.req_valid  = '1;
                bus.resp_ready = 1'b1;
            end else begin
                bus.req_valid  = N'($urandom);
                bus.resp_ready = ($urandom_range(0, 3) != 0);
            end
            #1;
            g = (!have && |bus.req_valid) ? rr_pick(m_last, bus.req_valid) : -1;
            check("rnd req_ready", 64'(bus.req_ready), (g >= 0) ? (64'(1) << g) : 64'(0));
            if (g >= 0) begin
                t_id   = g;
                t_exp  = ref_alu(ops[g], as_[g], bs_[g]);
                have   = 1'b1;
                acc_c  = c;
                m_last = g;
                if (fair && acc_n < 12) begin
                    check("rr order", 64'(g), 64'((start + 1 + acc_n) % N));
                    if (acc_n > 0) check("accept spacing", 64'(c - prev_acc), 3);
                end
                acc_n++;
                prev_acc = c;
            end else if (exp_rv && bus.resp_ready) begin
                have = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        check("rnd drain", 64'(have), 0);
        if (fair) check("fair accept count", 64'(acc_n >= 12), 1);
    endtask

    vec_t vecs [7];

    initial begin
        logic [32:0] exp_r;
        int          g;

        vecs[0] = '{0, OP_ADD, 32'hFFFF_FFFF, 32'h1,    32'h0000_0000, 1'b1, 1'b0, 1'b0, ALU_SEL_SUM};
        vecs[1] = '{2, OP_SUB, 32'h5,         32'h7,    32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, ALU_SEL_SUM};
        vecs[2] = '{2, OP_SUB, 32'h7,         32'h5,    32'h0000_0002, 1'b1, 1'b1, 1'b1, ALU_SEL_SUM};
        vecs[3] = '{1, OP_AND, 32'h0000_F0F0, 32'hFF00, 32'h0000_F000, 1'b0, 1'b0, 1'b0, ALU_SEL_AND};
        vecs[4] = '{1, OP_OR,  32'h0000_F0F0, 32'hFF00, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0, ALU_SEL_OR};
        vecs[5] = '{3, OP_ADD, 32'h7FFF_FFFF, 32'h1,    32'h8000_0000, 1'b0, 1'b0, 1'b0, ALU_SEL_SUM};
        vecs[6] = '{3, OP_SUB, 32'h0,         32'h0,    32'h0000_0000, 1'b1, 1'b1, 1'b1, ALU_SEL_SUM};

        bus.req_valid  = '0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;

        // Reset values
        @(posedge clk); @(posedge clk); #1;
        check_reset("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        foreach (vecs[i]) single_txn(vecs[i]);

        // All requesters valid: 12 accepts in strict rotation, 3 cycles apart
        run_random(36, 1'b1);

        // Randomized traffic and back-pressure
        run_random(400, 1'b0);

        // Stall: resp_ready low for 10 cycles in RESP
        for (int i = 0; i < N; i++) begin
            bus.req_op[2*i +: 2]  = 2'(i);
            bus.req_a[32*i +: 32] = 32'h1234_5678 + 32'(i);
            bus.req_b[32*i +: 32] = 32'h0F0F_0F0F;
        end
        bus.req_valid  = '1;
        bus.resp_ready = 1'b0;
        #1;
        g = rr_pick(m_last, bus.req_valid);
        check("stall grant", 64'(bus.req_ready), 64'(1) << g);
        exp_r  = ref_alu(2'(g), 32'h1234_5678 + 32'(g), 32'h0F0F_0F0F);
        m_last = g;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            bus.req_valid = N'($urandom);
            #1;
            check("stall req_ready", 64'(bus.req_ready), 0);
            check("stall resp_valid", 64'(bus.resp_valid), 1);
            check("stall resp_id", 64'(bus.resp_id), 64'(g));
            check("stall resp_result", 64'(bus.resp_result), 64'(exp_r[31:0]));
            check("stall resp_carry", 64'(bus.resp_carry), 64'(exp_r[32]));
            @(posedge clk); #1;
        end
        bus.req_valid  = '1;
        bus.resp_ready = 1'b1;
        #1;
        check("stall release no grant yet", 64'(bus.req_ready), 0);
        @(posedge clk); #1;
        check("stall resp_valid drop", 64'(bus.resp_valid), 0);
        g = rr_pick(m_last, bus.req_valid);
        check("stall next grant", 64'(bus.req_ready), 64'(1) << g);
        exp_r  = ref_alu(2'(g), 32'h1234_5678 + 32'(g), 32'h0F0F_0F0F);
        m_last = g;
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        check("post-stall resp_id", 64'(bus.resp_id), 64'(g));
        check("post-stall resp_result", 64'(bus.resp_result), 64'(exp_r[31:0]));
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;

        // Reset during EXEC drops the in-flight op
        bus.req_valid    = '0;
        bus.req_valid[2] = 1'b1;
        bus.req_op[5:4]  = OP_ADD;
        #1;
        check("rst-test grant", 64'(bus.req_ready), 64'b0100);
        @(posedge clk); #1;
        bus.req_valid  = '1;
        bus.req_op[1:0] = OP_SUB;
        bus.req_a[31:0] = 32'd100;
        bus.req_b[31:0] = 32'd30;
        bus.resp_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid-exec");
        m_last = N - 1;
        @(posedge clk); #1;
        check("in reset resp_valid", 64'(bus.resp_valid), 0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        check("after reset grant r0", 64'(bus.req_ready), 64'b0001);
        @(posedge clk); #1;
        bus.req_valid = '0;
        check("after reset no resp", 64'(bus.resp_valid), 0);
        @(posedge clk); #1;
        check("after reset resp_valid", 64'(bus.resp_valid), 1);
        check("after reset resp_id", 64'(bus.resp_id), 0);
        check("after reset resp_result", 64'(bus.resp_result), 64'd70);
        check("after reset resp_carry", 64'(bus.resp_carry), 1);
        @(posedge clk); #1;
        check("after reset resp drop", 64'(bus.resp_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
